// File: rtl/seq_pkg.sv
// Shared encodings for the SSM instruction sequencer: FSM states, opcodes
// and error codes.
package seq_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    FETCH    = 3'd1,
    DECODE   = 3'd2,
    DISPATCH = 3'd3,
    WAIT     = 3'd4,
    HALT     = 3'd5,
    ERROR    = 3'd6
  } state_t;

  localparam logic [3:0] OP_MOV   = 4'h0;
  localparam logic [3:0] OP_ADD   = 4'h1;
  localparam logic [3:0] OP_SUB   = 4'h2;
  localparam logic [3:0] OP_LOAD  = 4'h3;
  localparam logic [3:0] OP_STORE = 4'h4;
  localparam logic [3:0] OP_HALT  = 4'hF;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'b00,
    ERR_ILLEGAL = 2'b01,
    ERR_TIMEOUT = 2'b10
  } err_t;

endpackage

// File: rtl/watchdog_timer.sv
// Counts enabled cycles since the last clear; expired flags the TIMEOUT-th
// enabled cycle so the owner can abort in that same cycle.
module watchdog_timer #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  logic [TW-1:0] count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !expired) begin
      count <= count + TW'(1);
    end
  end

  // count holds the number of already-completed enabled cycles, so the
  // current cycle is the TIMEOUT-th one when count reaches TIMEOUT-1.
  assign expired = enable && (count == TW'(TIMEOUT - 1));

endmodule

// File: rtl/instr_sequencer.sv
// Top-level SSM instruction sequencer: fetch, decode, dispatch a start pulse
// to one micro-FSM, wait for its done, with a watchdog on the wait.
module instr_sequencer
  import seq_pkg::*;
#(
  parameter int unsigned    IW      = 16,
  parameter int unsigned    OPW     = 4,
  parameter int unsigned    NUM_OPS = 8,
  parameter logic [OPW-1:0] HALT_OP = OPW'(OP_HALT),
  parameter int unsigned    TIMEOUT = 15,
  parameter int unsigned    CW      = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               run,
  input  logic [IW-1:0]      instr,
  input  logic               mem_ready,
  input  logic [NUM_OPS-1:0] op_done,
  output logic               mem_rd,
  output logic               ir_load,
  output logic [NUM_OPS-1:0] op_start,
  output logic               busy,
  output logic               halted,
  output logic               error,
  output logic [1:0]         err_code,
  output logic [CW-1:0]      instr_count
);

  state_t             state;
  state_t             state_next;
  logic [OPW-1:0]     opcode;
  logic [NUM_OPS-1:0] op_sel;
  logic               op_legal;
  logic               done_sel;
  logic               wd_expired;
  logic               unused_instr_bits;

  assign unused_instr_bits = ^instr[IW-OPW-1:0];

  // op_sel is the start vector for the latched opcode; it is all-zero for
  // any opcode outside the micro-FSM range, which doubles as the legality test.
  always_comb begin
    op_sel = '0;
    for (int unsigned i = 0; i < NUM_OPS; i++) begin
      op_sel[i] = (opcode == OPW'(i));
    end
  end

  assign op_legal = |op_sel;
  assign done_sel = |(op_done & op_sel);

  watchdog_timer #(
    .TIMEOUT(TIMEOUT)
  ) u_watchdog (
    .clk    (clk),
    .reset  (reset),
    .clear  (state == DISPATCH),
    .enable (state == WAIT),
    .expired(wd_expired)
  );

  always_comb begin
    state_next = state;
    case (state)
      IDLE:     if (run) state_next = FETCH;
      FETCH:    if (mem_ready) state_next = DECODE;
      DECODE: begin
        if (op_legal)                state_next = DISPATCH;
        else if (opcode == HALT_OP)  state_next = HALT;
        else                         state_next = ERROR;
      end
      DISPATCH: state_next = WAIT;
      WAIT: begin
        if (done_sel)        state_next = run ? FETCH : IDLE;
        else if (wd_expired) state_next = ERROR;
      end
      HALT:     if (!run) state_next = IDLE;
      ERROR:    state_next = ERROR;
      default:  state_next = IDLE;
    endcase
  end

  // Outputs are registered from state_next so each one lines up exactly
  // with the state it decodes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      opcode      <= '0;
      instr_count <= '0;
      mem_rd      <= 1'b0;
      ir_load     <= 1'b0;
      op_start    <= '0;
      busy        <= 1'b0;
      halted      <= 1'b0;
      error       <= 1'b0;
      err_code    <= ERR_NONE;
    end else begin
      state <= state_next;

      if (state == FETCH && mem_ready) begin
        opcode <= instr[IW-1 -: OPW];
      end

      if (state == WAIT && done_sel) begin
        instr_count <= instr_count + CW'(1);
      end

      if (state == DECODE && state_next == ERROR) begin
        err_code <= ERR_ILLEGAL;
      end else if (state == WAIT && state_next == ERROR) begin
        err_code <= ERR_TIMEOUT;
      end

      mem_rd   <= (state_next == FETCH);
      ir_load  <= (state_next == DECODE);
      op_start <= (state_next == DISPATCH) ? op_sel : '0;
      busy     <= (state_next != IDLE) && (state_next != HALT) && (state_next != ERROR);
      halted   <= (state_next == HALT);
      error    <= (state_next == ERROR);
    end
  end

endmodule

// File: tb/tb_instr_sequencer.sv
// Randomized scoreboard bench for instr_sequencer: stimulus queues expected
// start pulses, a negedge monitor pops and compares them.
module tb_instr_sequencer;

  localparam int TIMEOUT = 15;

  logic        clk;
  logic        reset;
  logic        run;
  logic [15:0] instr;
  logic        mem_ready;
  logic [7:0]  op_done;
  logic        mem_rd;
  logic        ir_load;
  logic [7:0]  op_start;
  logic        busy;
  logic        halted;
  logic        error;
  logic [1:0]  err_code;
  logic [15:0] instr_count;

  int          total;
  int          bad;
  int          cyc;
  logic [15:0] model_count;

  typedef struct {
    logic [7:0] vec;
    int         cyc;
  } exp_t;
  exp_t exp_q[$];

  instr_sequencer #(
    .IW(16), .OPW(4), .NUM_OPS(8), .HALT_OP(4'hF), .TIMEOUT(TIMEOUT), .CW(16)
  ) dut (
    .clk(clk), .reset(reset), .run(run), .instr(instr), .mem_ready(mem_ready),
    .op_done(op_done), .mem_rd(mem_rd), .ir_load(ir_load), .op_start(op_start),
    .busy(busy), .halted(halted), .error(error), .err_code(err_code),
    .instr_count(instr_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every start pulse must match the oldest queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (op_start !== 8'h00) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_start", 32'(op_start), 32'h0);
        end else begin
          e = exp_q.pop_front();
          chk("start_vec", 32'(op_start), 32'(e.vec));
          chk("start_cycle", cyc, e.cyc);
        end
      end
    end
  end

  task automatic do_reset();
    reset = 1'b1;
    exp_q.delete();
    model_count = '0;
    #2;
    chk("rst_mem_rd", 32'(mem_rd), 0);
    chk("rst_op_start", 32'(op_start), 0);
    chk("rst_flags", {busy, halted, error, ir_load}, 0);
    chk("rst_err_code", 32'(err_code), 0);
    chk("rst_count", 32'(instr_count), 0);
    step();
    reset = 1'b0;
  endtask

  task automatic wait_fetch();
    for (int i = 0; i < 10 && mem_rd !== 1'b1; i++) step();
    chk("fetch_req", 32'(mem_rd), 1);
  endtask

  // Issue one instruction: fetch the opcode, then report done on the
  // done_lat-th WAIT cycle, with spurious done bits for other FSMs until then.
  task automatic do_instr(input logic [3:0] op, input int mem_lat, input int done_lat,
                          input bit run_after, input logic [7:0] spur);
    logic [7:0] oh;
    oh = 8'h01 << op;
    wait_fetch();
    for (int i = 0; i < mem_lat; i++) step();
    chk("mem_rd_hold", 32'(mem_rd), 1);
    instr = {op, 12'($urandom)};
    mem_ready = 1'b1;
    // DECODE for one cycle after the fetch edge, then DISPATCH.
    exp_q.push_back('{vec: oh, cyc: cyc + 2});
    step();
    mem_ready = 1'b0;
    instr = 16'($urandom);
    chk("ir_load", 32'(ir_load), 1);
    step();
    step();
    for (int k = 1; k < done_lat; k++) begin
      op_done = spur & ~oh;
      step();
    end
    if (!run_after) run = 1'b0;
    op_done = oh | (spur & ~oh);
    step();
    op_done = '0;
    model_count++;
    chk("count", 32'(instr_count), 32'(model_count));
    chk("mem_rd_after_done", 32'(mem_rd), 32'(run_after));
    chk("no_error", 32'(error), 0);
    if (!run_after) begin
      chk("idle_busy", 32'(busy), 0);
      step();
      chk("idle_stays", 32'(mem_rd), 0);
      run = 1'b1;
    end
  endtask

  initial begin
    total = 0; bad = 0; cyc = 0; model_count = '0;
    reset = 1'b1; run = 1'b0; instr = '0; mem_ready = 1'b0; op_done = '0;
    #1;
    do_reset();

    // MOV with memory latency 2, done 5 cycles after start.
    run = 1'b1;
    do_instr(4'h0, 2, 5, 1'b1, 8'h00);

    // ADD / SUB / STORE back to back, spurious done on FSM 3 during ADD.
    do_instr(4'h1, 0, 3, 1'b1, 8'h08);
    do_instr(4'h2, 1, 2, 1'b1, 8'h00);
    do_instr(4'h4, 0, 1, 1'b1, 8'h00);
    chk("count_after_three", 32'(instr_count), 4);

    // Illegal opcode 9.
    do_reset();
    run = 1'b1;
    wait_fetch();
    instr = 16'h9000; mem_ready = 1'b1;
    step();
    mem_ready = 1'b0;
    step();
    chk("illegal_error", 32'(error), 1);
    chk("illegal_code", 32'(err_code), 1);
    chk("illegal_busy", 32'(busy), 0);
    for (int i = 0; i < 4; i++) begin
      run = ~run;
      step();
      step();
    end
    chk("error_sticky", 32'(error), 1);
    chk("err_code_sticky", 32'(err_code), 1);
    chk("error_no_fetch", 32'(mem_rd), 0);

    // Timeout: opcode 2, never done.
    do_reset();
    run = 1'b1;
    wait_fetch();
    instr = 16'h2000; mem_ready = 1'b1;
    exp_q.push_back('{vec: 8'h04, cyc: cyc + 2});
    step();
    mem_ready = 1'b0;
    step();
    step();
    for (int i = 1; i < TIMEOUT; i++) step();
    chk("timeout_not_yet", 32'(error), 0);
    chk("timeout_busy", 32'(busy), 1);
    step();
    chk("timeout_error", 32'(error), 1);
    chk("timeout_code", 32'(err_code), 2);
    chk("timeout_count", 32'(instr_count), 0);

    // Done on the timeout cycle wins.
    do_reset();
    run = 1'b1;
    do_instr(4'h2, 0, TIMEOUT, 1'b1, 8'h00);

    // HALT, then release by dropping run.
    wait_fetch();
    instr = 16'hF000; mem_ready = 1'b1;
    step();
    mem_ready = 1'b0;
    step();
    chk("halted", 32'(halted), 1);
    chk("halt_busy", 32'(busy), 0);
    step(); step(); step();
    chk("halt_holds", 32'(halted), 1);
    run = 1'b0;
    step();
    chk("halt_release", 32'(halted), 0);
    chk("halt_idle_rd", 32'(mem_rd), 0);
    run = 1'b1;

    // Run dropped during WAIT: instruction completes then IDLE.
    do_instr(4'h3, 1, 4, 1'b0, 8'h00);

    // Randomized instruction stream.
    for (int n = 0; n < 30; n++) begin
      do_instr(4'($urandom_range(0, 7)), $urandom_range(0, 3), $urandom_range(1, TIMEOUT),
               ($urandom_range(0, 3) != 0), 8'($urandom));
    end

    // Asynchronous reset in WAIT with count 5.
    do_reset();
    run = 1'b1;
    for (int n = 0; n < 5; n++) do_instr(4'($urandom_range(0, 7)), 0, 2, 1'b1, 8'h00);
    wait_fetch();
    instr = 16'h1000; mem_ready = 1'b1;
    exp_q.push_back('{vec: 8'h02, cyc: cyc + 2});
    step();
    mem_ready = 1'b0;
    step();
    step();
    chk("pre_reset_count", 32'(instr_count), 5);
    chk("pre_reset_busy", 32'(busy), 1);
    #2;
    reset = 1'b1;
    #1;
    chk("async_count", 32'(instr_count), 0);
    chk("async_flags", {mem_rd, ir_load, busy, halted, error}, 0);
    chk("async_start_code", {op_start, err_code}, 0);
    step();
    reset = 1'b0;
    run = 1'b0;
    step();

    chk("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got hang expected finish");
    $fatal(1, "simulation time limit");
  end

endmodule
